// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and constants for the ALU operation scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } sched_state_e;

  localparam logic [3:0] OP_NOT  = 4'b0000;
  localparam logic [3:0] OP_TADD = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b1011;

  localparam int unsigned ST_BORROW  = 0;
  localparam int unsigned ST_ZERO    = 1;
  localparam int unsigned ST_CARRY   = 2;
  localparam int unsigned ST_ILLEGAL = 7;

  function automatic logic op_is_illegal(input logic [3:0] op, input logic [3:0] last_legal);
    return op > last_legal;
  endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Request, ALU and response signals of the scheduler; slave is the scheduler side.
interface alu_op_scheduler_if;

  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_regsel;
  logic [3:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_regsel;
  logic [3:0] req1_op;
  logic [3:0] alu_regsel;
  logic [3:0] alu_operation;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_borrow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [7:0] rsp_status;
  logic       rsp_id;

  modport slave (
    input  req0_valid, req0_regsel, req0_op, req1_valid, req1_regsel, req1_op,
    input  alu_result, alu_carry, alu_borrow, rsp_ready,
    output req0_ready, req1_ready, alu_regsel, alu_operation,
    output rsp_valid, rsp_result, rsp_status, rsp_id
  );

  modport master (
    output req0_valid, req0_regsel, req0_op, req1_valid, req1_regsel, req1_op,
    output alu_result, alu_carry, alu_borrow, rsp_ready,
    input  req0_ready, req1_ready, alu_regsel, alu_operation,
    input  rsp_valid, rsp_result, rsp_status, rsp_id
  );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only on an accepted grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  // ptr_q names the requester that wins a tie.
  logic ptr_q;

  always_comb begin
    gnt_id_o = (req_i == 2'b11) ? ptr_q : req_i[1];
    gnt_o    = 2'b00;
    if (req_i != 2'b00) begin
      gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (accept_i) begin
      ptr_q <= ~gnt_id_o;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: arbitrate, issue, settle, capture, respond.
// Define ALU_SCHED_STATS_EN to build the saturating completed-response counter.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned SettleCycles = 1,
  parameter logic [3:0]  LastLegalOp  = 4'b1011
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_scheduler_if.slave  bus,
  output logic [15:0]        op_count_o
);

  localparam logic [3:0] SettleLast = 4'(SettleCycles - 1);

  sched_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   regsel_q, op_q;
  logic         id_q, illegal_q;
  logic [7:0]   result_q, status_q, status_d;
  logic         rsp_id_q;
  logic [1:0]   gnt;
  logic         gnt_id, idle, req_hs, rsp_hs, capture;
  logic [3:0]   sel_regsel, sel_op;

  assign idle = (state_q == StIdle);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({bus.req1_valid, bus.req0_valid} & {2{idle}}),
    .accept_i (req_hs),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // A grant only exists for a valid requester in IDLE, so it is the handshake.
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign req_hs         = |gnt;
  assign sel_regsel     = gnt_id ? bus.req1_regsel : bus.req0_regsel;
  assign sel_op         = gnt_id ? bus.req1_op : bus.req0_op;
  assign capture        = (state_q == StIssue) && (cnt_q == SettleLast);
  assign rsp_hs         = (state_q == StResp) && bus.rsp_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          state_d = StIssue;
          cnt_d   = 4'd0;
        end
      end
      StIssue: begin
        if (capture) state_d = StResp;
        else         cnt_d   = cnt_q + 4'd1;
      end
      StResp: begin
        if (rsp_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    status_d              = 8'h00;
    status_d[ST_BORROW]   = (op_q == OP_SUB) & bus.alu_borrow;
    status_d[ST_ZERO]     = (bus.alu_result == 8'h00);
    status_d[ST_CARRY]    = ((op_q == OP_TADD) || (op_q == OP_ADD)) & bus.alu_carry;
    status_d[ST_ILLEGAL]  = illegal_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      regsel_q  <= 4'd0;
      op_q      <= 4'd0;
      id_q      <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 8'h00;
      status_q  <= 8'h00;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_hs) begin
        regsel_q  <= sel_regsel;
        op_q      <= sel_op;
        id_q      <= gnt_id;
        illegal_q <= op_is_illegal(sel_op, LastLegalOp);
      end
      if (capture) begin
        result_q <= bus.alu_result;
        status_q <= status_d;
        rsp_id_q <= id_q;
      end
    end
  end

  assign bus.alu_regsel    = regsel_q;
  assign bus.alu_operation = op_q;
  assign bus.rsp_valid     = (state_q == StResp);
  assign bus.rsp_result    = result_q;
  assign bus.rsp_status    = status_q;
  assign bus.rsp_id        = rsp_id_q;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= 16'h0000;
    end else if (rsp_hs && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count_o = op_count_q;
`else
  assign op_count_o = 16'h0000;
`endif

endmodule
